keypad_scan_ctrl: RTL

Scan sequencer for the 4x4 keypad matrix in the keyscan coder design. It walks a one-hot column drive and samples the row returns. It debounces single-key presses over whole scan frames and pushes each accepted key code into a small event FIFO, which downstream logic drains with a Valid/Ready handshake.

---
 rtl/keyscan_pkg.sv | 26 ++
 rtl/keyscan_fifo.sv | 54 +++++
 rtl/keypad_scan_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/keyscan_pkg.sv
// Shared types and the frame decoder for the 4x4 keypad scanner.
package keyscan_pkg;

  localparam int N_ROWS = 4;
  localparam int N_COLS = 4;
  localparam int KEY_W  = 4;

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_e;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} fclass_e;

  // Returns {more than one bit set, index of the highest set bit}.
  function automatic logic [KEY_W:0] frame_decode(input logic [N_ROWS*N_COLS-1:0] frame);
    logic [4:0]       n;
    logic [KEY_W-1:0] idx;
    n   = '0;
    idx = '0;
    for (int i = 0; i < N_ROWS*N_COLS; i++) begin
      if (frame[i]) begin
        n   = n + 5'd1;
        idx = KEY_W'(i);
      end
    end
    return {(n > 5'd1), idx};
  endfunction

endpackage

// File: rtl/keyscan_fifo.sv
// Small synchronous event FIFO; head visible the cycle after push, pop takes effect on the edge.
// A push while full is dropped unless a pop happens on the same edge.
module keyscan_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         vld,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW:0]             wr_q, wr_d, rd_q, rd_d;
  logic                    empty, full, pop_ok, push_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;

  assign vld      = !empty;
  assign head_dat = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_ok) begin
      mem_d[wr_q[AW-1:0]] = push_dat;
      wr_d                = wr_q + (AW+1)'(1);
    end
    if (pop_ok) rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with whole-frame debounce feeding a Valid/Ready event FIFO.
// Events push on the frame-end edge; a full FIFO drops new events and sets sticky Overflow.
module keypad_scan_ctrl
  import keyscan_pkg::*;
#(
  parameter int SCAN_DIV   = 4,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [N_ROWS-1:0] Row,
  output logic [N_COLS-1:0] Col,
  output logic [KEY_W-1:0]  Code,
  output logic              Valid,
  input  logic              Ready,
  output logic              Pressed,
  output logic              Overflow,
  input  logic              Clr_ovf
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE - 1);

  logic [DIV_W-1:0]             dwell_q, dwell_d;
  logic [1:0]                   col_idx_q, col_idx_d;
  logic [N_ROWS*N_COLS-1:0]     frame_q, frame_d, frame_cur;
  state_e                       state_q, state_d;
  logic [KEY_W-1:0]             cand_q, cand_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         ovf_q, ovf_d;
  logic                         sample, frame_end, push, drop;
  logic [KEY_W:0]               decoded;
  logic [KEY_W-1:0]             key;
  fclass_e                      fclass;

  assign sample    = (dwell_q == DWELL_LAST);
  assign frame_end = sample && (col_idx_q == 2'd3);
  assign Col       = N_COLS'(1) << col_idx_q;

  always_comb begin
    dwell_d   = sample ? '0 : dwell_q + DIV_W'(1);
    col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;
    frame_cur = frame_q;
    if (sample) begin
      for (int r = 0; r < N_ROWS; r++) frame_cur[{2'(r), col_idx_q}] = Row[r];
    end
    frame_d = frame_end ? '0 : frame_cur;
  end

  // Classification looks at the merged frame so the column-3 sample counts on its own edge.
  assign decoded = frame_decode(frame_cur);
  assign key     = decoded[KEY_W-1:0];
  assign fclass  = (frame_cur == '0) ? NONE : (decoded[KEY_W] ? MULTI : SINGLE);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (fclass == SINGLE) begin
            cand_d = key;
            if (DEBOUNCE == 1) begin
              push    = 1'b1;
              state_d = HELD;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = DB_PRESS;
            end
          end
        end
        DB_PRESS: begin
          if (fclass != SINGLE) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if (key != cand_q) begin
            cand_d = key;
            cnt_d  = CNT_W'(1);
          end else if (cnt_q == DB_LAST) begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = HELD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (fclass == NONE) begin
            cnt_d   = (DEBOUNCE == 1) ? '0 : CNT_W'(1);
            state_d = (DEBOUNCE == 1) ? IDLE : DB_RELEASE;
          end
        end
        DB_RELEASE: begin
          if (fclass != NONE) begin
            cnt_d   = '0;
            state_d = HELD;
          end else if (cnt_q == DB_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign Pressed = (state_q == HELD) || (state_q == DB_RELEASE);

  // A drop on the same edge as a clear wins, so no overflow is ever lost.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (Clr_ovf) ovf_d = 1'b0;
  end
  assign Overflow = ovf_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dwell_q   <= '0;
      col_idx_q <= '0;
      frame_q   <= '0;
      state_q   <= IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      dwell_q   <= dwell_d;
      col_idx_q <= col_idx_d;
      frame_q   <= frame_d;
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  keyscan_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (KEY_W)
  ) u_fifo (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .push     (push),
    .push_dat (cand_d),
    .pop      (Ready),
    .head_dat (Code),
    .vld      (Valid),
    .drop     (drop)
  );

endmodule
